// File: rtl/audio_meter_pkg.sv
// Shared types and helpers for the audio level meter: peak-hold states,
// default parameter values and the per-bin threshold function.
package audio_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DECAY = 2'd2
  } peak_state_e;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_NUM_CH       = 2;
  localparam int DEF_NUM_BINS     = 10;
  localparam int DEF_BIN_SHIFT    = 3;
  localparam int DEF_HOLD_CYCLES  = 25000000;
  localparam int DEF_DECAY_CYCLES = 2500000;
  localparam int GAIN_MAX         = 7;

  // Bin k lights when the magnitude reaches 2^(DATA_W-1-(NUM_BINS+1-k)*BIN_SHIFT);
  // exponents below zero collapse to a threshold of 1.
  function automatic logic [63:0] thr(input int k, input int data_w,
                                      input int num_bins, input int bin_shift);
    int e;
    e = data_w - 1 - (num_bins + 1 - k) * bin_shift;
    thr = (e < 0) ? 64'd1 : (64'd1 << e);
  endfunction

endpackage

// File: rtl/peak_hold_fsm.sv
// Peak-hold tracker: latches the highest level, holds it, then decays it
// one bin at a time until it returns to zero.
module peak_hold_fsm
  import audio_meter_pkg::*;
#(
  parameter int NUM_BINS     = DEF_NUM_BINS,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int DECAY_CYCLES = DEF_DECAY_CYCLES,
  parameter int LVL_W        = $clog2(NUM_BINS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] level,
  input  logic             level_valid,
  output logic [LVL_W-1:0] peak
);

  localparam int CNT_MAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DECAY_LAST = CNT_W'(DECAY_CYCLES - 1);

  peak_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             take;

  // a new level at or above the held peak restarts the hold window
  assign take = level_valid && (level >= peak);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      peak  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (level_valid && level != '0) begin
            peak  <= level;
            cnt   <= '0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (take) begin
            peak <= level;
            cnt  <= '0;
          end else if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= ST_DECAY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DECAY: begin
          if (take) begin
            peak  <= level;
            cnt   <= '0;
            state <= ST_HOLD;
          end else if (cnt == DECAY_LAST) begin
            cnt  <= '0;
            peak <= peak - LVL_W'(1);
            if (peak == LVL_W'(1)) state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          peak  <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/audio_level_meter.sv
// Multi-channel audio level meter: gain, saturating magnitude, max across
// channels, thermometer bar, sticky clip flags and a held peak dot.
module audio_level_meter
  import audio_meter_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int NUM_BINS     = DEF_NUM_BINS,
  parameter int BIN_SHIFT    = DEF_BIN_SHIFT,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int DECAY_CYCLES = DEF_DECAY_CYCLES
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [2:0]               gain,
  input  logic                     clip_clr,
  output logic [NUM_BINS-1:0]      level_bar,
  output logic [NUM_BINS-1:0]      peak_dot,
  output logic                     level_valid,
  output logic [NUM_CH-1:0]        clip
);

  localparam int STAGES = 2;
  localparam int MAG_W  = DATA_W - 1;
  localparam int WIDE_W = DATA_W + GAIN_MAX;
  localparam int LVL_W  = $clog2(NUM_BINS + 1);
  localparam logic [MAG_W-1:0] MAG_MAX = '1;

  logic [STAGES:1]                vld_pipe;
  logic [NUM_CH-1:0][MAG_W-1:0]   mag_d, mag_q;
  logic [MAG_W-1:0]               m;
  logic [NUM_BINS-1:0]            bar_d;
  logic [LVL_W-1:0]               lvl_d, lvl_q, peak;
  logic [NUM_CH-1:0]              clip_set;

  assign in_ready = 1'b1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] s, neg;
    logic [WIDE_W-1:0] w;
    logic              ovf;
    assign s = in_data[c*DATA_W +: DATA_W];
    assign w = {{GAIN_MAX{s[DATA_W-1]}}, s} << gain;
    // the shifted value fits only if everything above the new sign bit repeats it
    assign ovf = (w[WIDE_W-1:DATA_W-1] != {(GAIN_MAX+1){w[WIDE_W-1]}});
    assign neg = DATA_W'(0) - w[DATA_W-1:0];
    assign mag_d[c] = ovf               ? MAG_MAX :
                      !w[DATA_W-1]      ? w[MAG_W-1:0] :
                      neg[DATA_W-1]     ? MAG_MAX : neg[MAG_W-1:0];
    assign clip_set[c] = vld_pipe[1] && (mag_q[c] == MAG_MAX);
  end

  always_comb begin
    m = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (mag_q[c] > m) m = mag_q[c];
  end

  always_comb begin
    bar_d = '0;
    lvl_d = '0;
    for (int k = 0; k < NUM_BINS; k++) begin
      if (64'(m) >= thr(k + 1, DATA_W, NUM_BINS, BIN_SHIFT)) begin
        bar_d[k] = 1'b1;
        lvl_d    = lvl_d + LVL_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      mag_q     <= '0;
      level_bar <= '0;
      lvl_q     <= '0;
      clip      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) mag_q <= mag_d;
      if (vld_pipe[1]) begin
        level_bar <= bar_d;
        lvl_q     <= lvl_d;
      end
      // a new clip event in the same cycle as a clear keeps its flag set
      clip <= (clip_clr ? '0 : clip) | clip_set;
    end
  end

  assign level_valid = vld_pipe[STAGES];

  peak_hold_fsm #(
    .NUM_BINS     (NUM_BINS),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .DECAY_CYCLES (DECAY_CYCLES),
    .LVL_W        (LVL_W)
  ) u_peak (
    .clk         (CLOCK_50),
    .rst         (reset),
    .level       (lvl_q),
    .level_valid (level_valid),
    .peak        (peak)
  );

  always_comb begin
    peak_dot = '0;
    for (int k = 0; k < NUM_BINS; k++)
      peak_dot[k] = (peak == LVL_W'(k + 1));
  end

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench for audio_level_meter with an arithmetic reference model
// checked every cycle, plus literal expectations at key points.
module tb_audio_level_meter;

  localparam int DW = 32, NC = 2, NB = 10, BS = 3, HOLD = 8, DECAY = 4;

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, clip_clr = 1'b0;
  logic [NC*DW-1:0] in_data = '0;
  logic [2:0]       gain = '0;
  logic             in_ready, level_valid;
  logic [NB-1:0]    level_bar, peak_dot;
  logic [NC-1:0]    clip;

  int n_chk = 0, n_fail = 0;
  bit chk_on = 0;

  audio_level_meter #(
    .DATA_W(DW), .NUM_CH(NC), .NUM_BINS(NB), .BIN_SHIFT(BS),
    .HOLD_CYCLES(HOLD), .DECAY_CYCLES(DECAY)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .gain(gain), .clip_clr(clip_clr),
    .level_bar(level_bar), .peak_dot(peak_dot), .level_valid(level_valid), .clip(clip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NB-1:0] e_bar = '0;
  bit            e_lv = 0;
  logic [NC-1:0] e_clip = '0;
  int            e_L = 0, pk_cap = 0, pk_age = 0, cyc = 0;
  bit            pend_v[4];
  int            pend_L[4];
  logic [NC-1:0] pend_set[4];

  function automatic longint mag_max();
    return (longint'(1) << (DW - 1)) - 1;
  endfunction

  function automatic longint sat_mag(input logic [DW-1:0] s, input int g);
    longint v;
    v = longint'($signed(s)) * (longint'(1) << g);
    if (v > mag_max() || v < -mag_max() - 1) return mag_max();
    if (v < 0) v = -v;
    return (v > mag_max()) ? mag_max() : v;
  endfunction

  function automatic int level_of(input longint mg);
    int L, e;
    longint t;
    L = 0;
    for (int k = 1; k <= NB; k++) begin
      e = DW - 1 - (NB + 1 - k) * BS;
      t = (e < 0) ? 1 : (longint'(1) << e);
      if (mg >= t) L++;
    end
    return L;
  endfunction

  // held peak as a function of the captured level and cycles since capture
  function automatic int peak_now();
    int p;
    if (pk_cap == 0) return 0;
    if (pk_age < HOLD) return pk_cap;
    p = pk_cap - (pk_age - HOLD) / DECAY;
    return (p < 0) ? 0 : p;
  endfunction

  function automatic logic [NB-1:0] dot_of(input int p);
    logic [NB-1:0] one;
    one = 1;
    return (p > 0) ? (one << (p - 1)) : '0;
  endfunction

  initial begin
    forever begin
      int slot;
      longint mg, best;
      logic [NC-1:0] setb;
      @(posedge clk or posedge rst);
      if (rst) begin
        e_bar = '0; e_lv = 0; e_clip = '0; e_L = 0; pk_cap = 0; pk_age = 0;
        for (int i = 0; i < 4; i++) begin pend_v[i] = 0; pend_set[i] = '0; pend_L[i] = 0; end
      end else begin
        if (e_lv && e_L > 0 && e_L >= peak_now()) begin
          pk_cap = e_L; pk_age = 0;
        end else if (pk_cap > 0) begin
          pk_age++;
          if (peak_now() == 0) pk_cap = 0;
        end
        slot   = (cyc + 1) % 4;
        e_clip = (clip_clr ? '0 : e_clip) | pend_set[slot];
        e_lv   = pend_v[slot];
        if (pend_v[slot]) begin
          e_L   = pend_L[slot];
          e_bar = NB'((longint'(1) << e_L) - 1);
        end
        pend_v[slot] = 0; pend_set[slot] = '0;
        if (in_valid) begin
          best = 0; setb = '0;
          for (int c = 0; c < NC; c++) begin
            mg = sat_mag(in_data[c*DW +: DW], int'(gain));
            if (mg == mag_max()) setb[c] = 1'b1;
            if (mg > best) best = mg;
          end
          slot = (cyc + 2) % 4;
          pend_v[slot] = 1; pend_L[slot] = level_of(best); pend_set[slot] = setb;
        end
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("level_bar", level_bar, e_bar);
        chk("level_valid", level_valid, e_lv);
        chk("peak_dot", peak_dot, dot_of(peak_now()));
        chk("clip", clip, e_clip);
        chk("in_ready", in_ready, 1);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send_chk(input string name, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [2:0] g, input logic [NB-1:0] eb, input logic [NC-1:0] ec);
    @(posedge clk); #1 in_valid = 1; in_data = {d1, d0}; gain = g;
    @(posedge clk); #1 in_valid = 0;
    chk({name, "_early"}, level_valid, 0);
    @(posedge clk); #1;
    chk({name, "_valid"}, level_valid, 1);
    chk({name, "_bar"}, level_bar, eb);
    chk({name, "_clip"}, clip, ec);
    @(posedge clk); #1;
    chk({name, "_pulse"}, level_valid, 0);
    chk({name, "_holdbar"}, level_bar, eb);
  endtask

  initial begin
    logic [DW-1:0] r;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bar", level_bar, 0);
    chk("rst_dot", peak_dot, 0);
    chk("rst_valid", level_valid, 0);
    chk("rst_clip", clip, 0);
    rst = 0;
    chk_on = 1;

    // peak hold and decay from a single L=7 sample
    @(posedge clk); #1 in_valid = 1; in_data = {32'h0, 32'h0010_0000}; gain = 0;
    @(posedge clk); #1 in_valid = 0;
    for (int i = 2; i <= 40; i++) begin
      @(posedge clk); #1;
      case (i)
        2: begin
          chk("pk_bar", level_bar, 10'b0001111111);
          chk("pk_before", peak_dot, 10'b0);
        end
        3, 10, 14: chk("pk_hold", peak_dot, 10'b0001000000);
        15:        chk("pk_step1", peak_dot, 10'b0000100000);
        38:        chk("pk_last", peak_dot, 10'b0000000001);
        39, 40:    chk("pk_idle", peak_dot, 10'b0);
        default: ;
      endcase
    end

    send_chk("req040", 32'h0000_0100, 32'h0, 3'd0, 10'b0000000111, 2'b00);
    send_chk("req041", 32'h0000_0100, 32'h0, 3'd3, 10'b0000001111, 2'b00);
    send_chk("req045", 32'h0000_0004, 32'hFFF0_0000, 3'd0, 10'b0001111111, 2'b00);
    send_chk("req042", 32'h4000_0000, 32'h0, 3'd1, 10'b1111111111, 2'b01);

    @(posedge clk); #1 clip_clr = 1;
    @(posedge clk); #1 clip_clr = 0;
    chk("req043_clr", clip, 2'b00);

    send_chk("req044", 32'h0, 32'h8000_0000, 3'd0, 10'b1111111111, 2'b10);

    // set and clear in the same cycle: ch0 sets, ch1 clears
    @(posedge clk); #1 in_valid = 1; in_data = {32'h0, 32'h0100_0000}; gain = 3'd7;
    @(posedge clk); #1 in_valid = 0; clip_clr = 1;
    @(posedge clk); #1 clip_clr = 0;
    chk("set_wins", clip, 2'b01);
    chk("set_wins_bar", level_bar, 10'b1111111111);
    @(posedge clk); #1 clip_clr = 1;
    @(posedge clk); #1 clip_clr = 0;

    // back-to-back pair
    @(posedge clk); #1 in_valid = 1; in_data = {32'h0, 32'h0000_0100}; gain = 0;
    @(posedge clk); #1 in_data = {32'h0, 32'h0000_0010};
    @(posedge clk); #1 in_valid = 0;
    chk("b2b_first", level_bar, 10'b0000000111);
    @(posedge clk); #1;
    chk("b2b_second", level_bar, 10'b0000000011);
    chk("b2b_valid", level_valid, 1);
    @(posedge clk); #1;
    chk("b2b_end", level_valid, 0);

    // random back-to-back traffic, checked by the model
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      gain     = 3'($urandom_range(0, 7));
      clip_clr = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < NC; c++) begin
        r = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) r = -r;
        if ($urandom_range(0, 15) == 0) r = 32'h8000_0000;
        in_data[c*DW +: DW] = r;
      end
    end
    @(posedge clk); #1 in_valid = 0; clip_clr = 0;
    repeat (60) @(posedge clk);

    // reset in the middle of a decay with a sample in flight
    @(posedge clk); #1 in_valid = 1; in_data = {32'h0, 32'h0010_0000}; gain = 0;
    @(posedge clk); #1 in_valid = 0;
    repeat (19) @(posedge clk);
    #1 chk("decay_mid", peak_dot, 10'b0000010000);
    @(posedge clk); #1 in_valid = 1; in_data = {32'h8000_0000, 32'h8000_0000};
    @(posedge clk); #3 rst = 1;
    #1 in_valid = 0;
    chk("arst_bar", level_bar, 0);
    chk("arst_dot", peak_dot, 0);
    chk("arst_valid", level_valid, 0);
    chk("arst_clip", clip, 0);
    @(posedge clk); @(posedge clk); #3 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("flush_valid", level_valid, 0);
      chk("flush_clip", clip, 0);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_level_meter.md
AUDIO_LEVEL_METER -- requirements
Module: audio_level_meter

Interface
REQ-001 Parameter DATA_W, default 32: sample width, two's complement.
REQ-002 Parameter NUM_CH, default 2: audio channel count.
REQ-003 Parameter NUM_BINS, default 10: LED bar length.
REQ-004 Parameter BIN_SHIFT, default 3: bits per bin, about 18 dB per bin.
REQ-005 Parameter HOLD_CYCLES, default 25000000: peak hold time, in clocks.
REQ-006 Parameter DECAY_CYCLES, default 2500000: clocks per one-bin peak decay step.
REQ-007 CLOCK_50  in  1  sole clock; all flops rise on it.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 in_valid  in  1  sample strobe.
REQ-010 in_ready  out  1  tied to 1; block never stalls.
REQ-011 in_data  in  NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W].
REQ-012 gain  in  3  left-shift amount, 0..7; sampled with in_valid.
REQ-013 clip_clr  in  1  clears all sticky clip flags.
REQ-014 level_bar  out  NUM_BINS  thermometer code of the current level.
REQ-015 peak_dot  out  NUM_BINS  one-hot held-peak bin, or all zero.
REQ-016 level_valid  out  1  one-cycle pulse when level_bar updates.
REQ-017 clip  out  NUM_CH  sticky per-channel clip flag.

Function
REQ-018 Stage 1 (registered) SHALL compute, per channel, the shifted value s<<gain with saturation: on overflow, the magnitude clamps to 2^(DATA_W-1)-1.
REQ-019 Stage 1 SHALL take the absolute value, with abs(-2^(DATA_W-1)) = 2^(DATA_W-1)-1; no wrap-around is permitted.
REQ-020 Stage 2 (registered) SHALL form m = max over channels of the stage-1 magnitude.
REQ-021 Level L = count of k in 1..NUM_BINS with m >= 2^(DATA_W-1-(NUM_BINS+1-k)*BIN_SHIFT); level_bar = L ones, LSB-aligned.
REQ-022 Any threshold exponent below 0 SHALL be treated as threshold 1.
REQ-023 Latency SHALL be 2: in_valid at cycle t gives level_bar and level_valid at t+2; back-to-back samples every cycle are supported.
REQ-024 level_bar SHALL hold its value between level_valid pulses.
REQ-025 clip[c] SHALL set when channel c's stage-1 magnitude equals 2^(DATA_W-1)-1.
REQ-026 clip[c] SHALL clear only on clip_clr; if set and clear coincide, set wins.
REQ-027 Peak-hold FSM states: IDLE, HOLD, DECAY; register P holds the peak level, counter cnt holds elapsed clocks.
REQ-028 IDLE: P=0. On level_valid with L>0: P<=L, cnt<=0, go to HOLD.
REQ-029 HOLD: cnt increments each clock. Any level_valid with L>=P: P<=L, cnt<=0. At cnt=HOLD_CYCLES-1: cnt<=0, go to DECAY.
REQ-030 DECAY: cnt increments each clock. At cnt=DECAY_CYCLES-1: P<=P-1, cnt<=0.
REQ-031 DECAY exits: when P reaches 0, go to IDLE. A level_valid with L>=P takes priority over decrement: P<=L, go to HOLD.
REQ-032 peak_dot SHALL be bit P-1 set when P>0, else zero; it is driven combinationally from P.
REQ-033 Counter width SHALL be $clog2 of max(HOLD_CYCLES, DECAY_CYCLES).

Reset
REQ-034 Asserting reset SHALL asynchronously zero all pipeline registers, level_bar, peak_dot, level_valid, clip, P and cnt, and force the FSM to IDLE.
REQ-035 Samples in flight during reset SHALL be discarded.
REQ-036 The first level_valid SHALL come no earlier than 2 cycles after the first in_valid following reset deassertion.

Structure
REQ-037 Package audio_meter_pkg SHALL hold the FSM state enum, default parameter constants, and a threshold function thr(k) for the REQ-021/022 computation.
REQ-038 Peak logic SHALL live in sub-module peak_hold_fsm (inputs L, level_valid; outputs P).
REQ-039 Saturating shift, abs, max and thermometer logic SHALL stay in the top module.

Verification (DATA_W=32, NUM_CH=2, NUM_BINS=10, BIN_SHIFT=3; thresholds 2^(3k-2))
REQ-040 ch0=0x00000100, ch1=0, gain=0 -> level_bar=0000000111 exactly 2 cycles later, with one level_valid pulse.
REQ-041 Same sample, gain=3 -> level_bar=0000001111; clip=00.
REQ-042 ch0=0x40000000, gain=1 -> saturates: level_bar=1111111111, clip[0]=1.
REQ-043 ch0=0x40000000, gain=1, then clip_clr held -> clip[0] clears next cycle.
REQ-044 ch1=0x80000000, gain=0 -> level_bar=1111111111, clip[1]=1.
REQ-045 ch0=4, ch1=0xFFF00000 (-2^20) -> level_bar=0001111111 (max-of-channels).
REQ-046 HOLD_CYCLES=8, DECAY_CYCLES=4: one sample at L=7 then zeros -> peak_dot=0001000000 for 8 cycles, then shifts down one bin every 4 cycles, reaching 0 and IDLE after 28 further cycles; assert reset mid-decay -> all outputs 0 immediately.
